// File: rtl/csr_file.sv
// LoongArch privileged CSR file: WB-stage CSR read/write port, exception and ertn
// state updates, interrupt status sampling and the constant timer.
module csr_file #(
  parameter logic [31:0] CORE_ID = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_re,
  input  logic [13:0] csr_rd_num,
  output logic [31:0] csr_rd_value,
  input  logic        csr_we,
  input  logic [13:0] csr_wr_num,
  input  logic [31:0] csr_wr_mask,
  input  logic [31:0] csr_wr_value,
  input  logic [13:0] wb_exc,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_fault_vaddr,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_pc
);

  localparam logic [13:0] ADDR_CRMD   = 14'h000;
  localparam logic [13:0] ADDR_PRMD   = 14'h001;
  localparam logic [13:0] ADDR_ECFG   = 14'h004;
  localparam logic [13:0] ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] ADDR_ERA    = 14'h006;
  localparam logic [13:0] ADDR_BADV   = 14'h007;
  localparam logic [13:0] ADDR_EENTRY = 14'h00C;
  localparam logic [13:0] ADDR_SAVE0  = 14'h030;
  localparam logic [13:0] ADDR_SAVE1  = 14'h031;
  localparam logic [13:0] ADDR_SAVE2  = 14'h032;
  localparam logic [13:0] ADDR_SAVE3  = 14'h033;
  localparam logic [13:0] ADDR_TID    = 14'h040;
  localparam logic [13:0] ADDR_TCFG   = 14'h041;
  localparam logic [13:0] ADDR_TVAL   = 14'h042;
  localparam logic [13:0] ADDR_TICLR  = 14'h044;
  localparam logic [13:0] ADDR_TLBREN = 14'h088;

  logic [1:0]  r_crmd_plv;
  logic        r_crmd_ie, r_crmd_da, r_crmd_pg;
  logic [1:0]  r_prmd_pplv;
  logic        r_prmd_pie;
  logic [12:0] r_ecfg_lie;
  logic [1:0]  r_is_sw;
  logic [7:0]  r_is_hw;
  logic        r_is_timer, r_is_ipi;
  logic [5:0]  r_estat_ecode;
  logic [8:0]  r_estat_esub;
  logic [31:0] r_era, r_badv;
  logic [25:0] r_eentry_va, r_tlbrentry_pa;
  logic [31:0] r_save0, r_save1, r_save2, r_save3, r_tid;
  logic        r_tcfg_en, r_tcfg_periodic;
  logic [29:0] r_tcfg_initval;
  logic [31:0] r_tval;

  logic [31:0] w_crmd, w_prmd, w_ecfg, w_estat, w_eentry, w_tcfg, w_tlbrentry;
  logic [12:0] w_estat_is;
  logic [31:0] w_wr_old, w_wr_merged;
  logic        w_exc, w_ertn, w_sw_we, w_exc_tlbr, w_timer_fire, w_ticlr_clr;
  logic        w_wr_crmd, w_wr_prmd, w_wr_ecfg, w_wr_estat, w_wr_tcfg;
  logic [3:0]  w_exc_idx;
  logic [5:0]  w_exc_ecode;
  logic [8:0]  w_exc_esub;
  logic        w_badv_sel_pc, w_badv_sel_va;
  logic        w_unused;

  assign w_unused    = csr_re;
  assign w_estat_is  = {r_is_ipi, r_is_timer, 1'b0, r_is_hw, r_is_sw};
  assign w_crmd      = {27'h0, r_crmd_pg, r_crmd_da, r_crmd_ie, r_crmd_plv};
  assign w_prmd      = {29'h0, r_prmd_pie, r_prmd_pplv};
  assign w_ecfg      = {19'h0, r_ecfg_lie};
  assign w_estat     = {1'b0, r_estat_esub, r_estat_ecode, 3'h0, w_estat_is};
  assign w_eentry    = {r_eentry_va, 6'h0};
  assign w_tcfg      = {r_tcfg_initval, r_tcfg_periodic, r_tcfg_en};
  assign w_tlbrentry = {r_tlbrentry_pa, 6'h0};

  function automatic logic [31:0] csr_mux(input logic [13:0] num);
    case (num)
      ADDR_CRMD:   return w_crmd;
      ADDR_PRMD:   return w_prmd;
      ADDR_ECFG:   return w_ecfg;
      ADDR_ESTAT:  return w_estat;
      ADDR_ERA:    return r_era;
      ADDR_BADV:   return r_badv;
      ADDR_EENTRY: return w_eentry;
      ADDR_SAVE0:  return r_save0;
      ADDR_SAVE1:  return r_save1;
      ADDR_SAVE2:  return r_save2;
      ADDR_SAVE3:  return r_save3;
      ADDR_TID:    return r_tid;
      ADDR_TCFG:   return w_tcfg;
      ADDR_TVAL:   return r_tval;
      ADDR_TLBREN: return w_tlbrentry;
      default:     return 32'h0;
    endcase
  endfunction

  always_comb begin
    csr_rd_value = csr_mux(csr_rd_num);
    w_wr_old     = csr_mux(csr_wr_num);
  end

  assign w_wr_merged = (w_wr_old & ~csr_wr_mask) | (csr_wr_value & csr_wr_mask);

  // Exceptions and ertn retire instead of the CSR instruction, so they block its write.
  assign w_exc       = |wb_exc;
  assign w_ertn      = ertn_flush & ~w_exc;
  assign w_sw_we     = csr_we & ~w_exc & ~ertn_flush;
  assign w_wr_crmd   = w_sw_we & (csr_wr_num == ADDR_CRMD);
  assign w_wr_prmd   = w_sw_we & (csr_wr_num == ADDR_PRMD);
  assign w_wr_ecfg   = w_sw_we & (csr_wr_num == ADDR_ECFG);
  assign w_wr_estat  = w_sw_we & (csr_wr_num == ADDR_ESTAT);
  assign w_wr_tcfg   = w_sw_we & (csr_wr_num == ADDR_TCFG);
  assign w_ticlr_clr = w_sw_we & (csr_wr_num == ADDR_TICLR) & w_wr_merged[0];

  always_comb begin
    w_exc_idx = 4'd0;
    for (int i = 13; i >= 0; i--) begin
      if (wb_exc[i]) w_exc_idx = 4'(i);
    end
  end

  always_comb begin
    w_exc_ecode   = 6'h00;
    w_exc_esub    = 9'h000;
    w_badv_sel_pc = 1'b0;
    w_badv_sel_va = 1'b0;
    case (w_exc_idx)
      4'd1:  begin w_exc_ecode = 6'h08; w_badv_sel_pc = 1'b1; end
      4'd2:  begin w_exc_ecode = 6'h3F; w_badv_sel_va = 1'b1; end
      4'd3:  begin w_exc_ecode = 6'h03; w_badv_sel_va = 1'b1; end
      4'd4:  begin w_exc_ecode = 6'h07; w_badv_sel_va = 1'b1; end
      4'd5:  w_exc_ecode = 6'h0D;
      4'd6:  w_exc_ecode = 6'h0B;
      4'd7:  w_exc_ecode = 6'h0C;
      4'd8:  begin w_exc_ecode = 6'h09; w_badv_sel_va = 1'b1; end
      4'd9:  begin w_exc_ecode = 6'h08; w_exc_esub = 9'h001; w_badv_sel_va = 1'b1; end
      4'd10: begin w_exc_ecode = 6'h01; w_badv_sel_va = 1'b1; end
      4'd11: begin w_exc_ecode = 6'h02; w_badv_sel_va = 1'b1; end
      4'd12: begin w_exc_ecode = 6'h04; w_badv_sel_va = 1'b1; end
      4'd13: begin w_exc_ecode = 6'h07; w_badv_sel_va = 1'b1; end
      default: ;
    endcase
  end

  assign w_exc_tlbr   = w_exc & (w_exc_idx == 4'd2);
  assign w_timer_fire = r_tcfg_en & (r_tval == 32'h0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crmd_plv  <= 2'b00;
      r_crmd_ie   <= 1'b0;
      r_crmd_da   <= 1'b1;
      r_crmd_pg   <= 1'b0;
      r_prmd_pplv <= 2'b00;
      r_prmd_pie  <= 1'b0;
    end else if (w_exc) begin
      r_prmd_pplv <= r_crmd_plv;
      r_prmd_pie  <= r_crmd_ie;
      r_crmd_plv  <= 2'b00;
      r_crmd_ie   <= 1'b0;
      if (w_exc_tlbr) begin
        r_crmd_da <= 1'b1;
        r_crmd_pg <= 1'b0;
      end
    end else if (w_ertn) begin
      r_crmd_plv <= r_prmd_pplv;
      r_crmd_ie  <= r_prmd_pie;
      if (r_estat_ecode == 6'h3F) begin
        r_crmd_da <= 1'b0;
        r_crmd_pg <= 1'b1;
      end
    end else begin
      if (w_wr_crmd) begin
        r_crmd_plv <= w_wr_merged[1:0];
        r_crmd_ie  <= w_wr_merged[2];
        r_crmd_da  <= w_wr_merged[3];
        r_crmd_pg  <= w_wr_merged[4];
      end
      if (w_wr_prmd) begin
        r_prmd_pplv <= w_wr_merged[1:0];
        r_prmd_pie  <= w_wr_merged[2];
      end
    end
  end

  // IS[9:2] and IS[12] follow the interrupt lines every cycle; software only owns IS[1:0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ecfg_lie    <= '0;
      r_is_sw       <= '0;
      r_is_hw       <= '0;
      r_is_timer    <= 1'b0;
      r_is_ipi      <= 1'b0;
      r_estat_ecode <= '0;
      r_estat_esub  <= '0;
    end else begin
      r_is_hw  <= hw_int_in;
      r_is_ipi <= ipi_int_in;
      if (w_wr_ecfg) r_ecfg_lie <= {w_wr_merged[12:11], 1'b0, w_wr_merged[9:0]};
      if (w_wr_estat) r_is_sw <= w_wr_merged[1:0];
      if (w_timer_fire) r_is_timer <= 1'b1;
      else if (w_ticlr_clr) r_is_timer <= 1'b0;
      if (w_exc) begin
        r_estat_ecode <= w_exc_ecode;
        r_estat_esub  <= w_exc_esub;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_era          <= '0;
      r_badv         <= '0;
      r_eentry_va    <= '0;
      r_tlbrentry_pa <= '0;
      r_save0        <= '0;
      r_save1        <= '0;
      r_save2        <= '0;
      r_save3        <= '0;
      r_tid          <= CORE_ID;
    end else if (w_exc) begin
      r_era <= wb_pc;
      if (w_badv_sel_pc) r_badv <= wb_pc;
      else if (w_badv_sel_va) r_badv <= wb_fault_vaddr;
    end else if (w_sw_we) begin
      case (csr_wr_num)
        ADDR_ERA:    r_era          <= w_wr_merged;
        ADDR_BADV:   r_badv         <= w_wr_merged;
        ADDR_EENTRY: r_eentry_va    <= w_wr_merged[31:6];
        ADDR_TLBREN: r_tlbrentry_pa <= w_wr_merged[31:6];
        ADDR_SAVE0:  r_save0        <= w_wr_merged;
        ADDR_SAVE1:  r_save1        <= w_wr_merged;
        ADDR_SAVE2:  r_save2        <= w_wr_merged;
        ADDR_SAVE3:  r_save3        <= w_wr_merged;
        ADDR_TID:    r_tid          <= w_wr_merged;
        default: ;
      endcase
    end
  end

  // A one-shot timer parks at all-ones after expiry so it cannot fire again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcfg_en       <= 1'b0;
      r_tcfg_periodic <= 1'b0;
      r_tcfg_initval  <= '0;
      r_tval          <= '0;
    end else if (w_wr_tcfg) begin
      r_tcfg_en       <= w_wr_merged[0];
      r_tcfg_periodic <= w_wr_merged[1];
      r_tcfg_initval  <= w_wr_merged[31:2];
      r_tval          <= {w_wr_merged[31:2], 2'b00};
    end else if (r_tcfg_en) begin
      if (r_tval == 32'h0)
        r_tval <= r_tcfg_periodic ? {r_tcfg_initval, 2'b00} : 32'hFFFF_FFFF;
      else if (r_tval != 32'hFFFF_FFFF)
        r_tval <= r_tval - 32'd1;
    end
  end

  assign has_int  = r_crmd_ie & |(w_estat_is & r_ecfg_lie);
  assign ex_entry = wb_exc[2] ? w_tlbrentry : w_eentry;
  assign ertn_pc  = r_era;

endmodule
